// File: rtl/hwpe_stream_streamer_sequencer.sv
// ---------------------------------------------------------------------------
// hwpe_stream_streamer_sequencer
//
// Steps a group of HWPE streamers through a programmed number of iterations.
// Each iteration waits until every enabled streamer reports ready_start,
// fires one synchronized req_start pulse to all of them, then collects one
// done from each enabled streamer before moving on.
//
// Optional feature macro: HWPE_STREAM_SEQ_PERF_EN
//   When defined, a 32-bit cycles_o port is added. It counts the cycles with
//   busy_o high and saturates at all-ones. It is cleared when a start is
//   accepted and on reset or clear, and it holds its value after the job ends.
//   When the macro is undefined there is no cycles_o port and no counter.
// ---------------------------------------------------------------------------
module hwpe_stream_streamer_sequencer #(
    parameter int unsigned NB_STREAMS = 3,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  start_i,
    input  logic [CNT_WIDTH-1:0]  nb_iter_i,
    input  logic [NB_STREAMS-1:0] stream_mask_i,
    input  logic [NB_STREAMS-1:0] ready_start_i,
    input  logic [NB_STREAMS-1:0] done_i,
    output logic [NB_STREAMS-1:0] req_start_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [CNT_WIDTH-1:0]  iter_o
`ifdef HWPE_STREAM_SEQ_PERF_EN
    ,
    output logic [31:0]           cycles_o
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_READY = 3'd1,
        ST_START      = 3'd2,
        ST_WORKING    = 3'd3,
        ST_DONE       = 3'd4
    } state_e;

    localparam logic [CNT_WIDTH-1:0]  ITER_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0]  ITER_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [NB_STREAMS-1:0] MASK_ZERO = {NB_STREAMS{1'b0}};

    state_e                  state_q,      state_d;
    logic [CNT_WIDTH-1:0]    nb_iter_q,    nb_iter_d;
    logic [NB_STREAMS-1:0]   mask_q,       mask_d;
    logic [CNT_WIDTH-1:0]    iter_q,       iter_d;
    logic [NB_STREAMS-1:0]   done_seen_q,  done_seen_d;
    logic [NB_STREAMS-1:0]   req_start_q,  req_start_d;
    logic                    busy_q,       busy_d;
    logic                    done_q,       done_d;

    logic [NB_STREAMS-1:0]   done_merged_s;
    logic [CNT_WIDTH-1:0]    iter_inc_s;

    // Next-state, latched job configuration and iteration bookkeeping.
    always_comb begin
        state_d       = state_q;
        nb_iter_d     = nb_iter_q;
        mask_d        = mask_q;
        iter_d        = iter_q;
        done_seen_d   = done_seen_q;
        // A done arriving in the same cycle as the last missing one still counts.
        done_merged_s = done_seen_q | (done_i & mask_q);
        iter_inc_s    = iter_q + ITER_ONE;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    nb_iter_d = nb_iter_i;
                    mask_d    = stream_mask_i;
                    iter_d    = ITER_ZERO;
                    // An empty job (nothing to iterate or nobody enabled) just signals completion.
                    if ((nb_iter_i == ITER_ZERO) || (stream_mask_i == MASK_ZERO)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WAIT_READY;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_READY: begin
                if ((ready_start_i & mask_q) == mask_q) begin
                    state_d = ST_START;
                end else begin
                    state_d = ST_WAIT_READY;
                end
            end
            ST_START: begin
                done_seen_d = MASK_ZERO;
                state_d     = ST_WORKING;
            end
            ST_WORKING: begin
                done_seen_d = done_merged_s;
                if (done_merged_s == mask_q) begin
                    iter_d = iter_inc_s;
                    if (iter_inc_s == nb_iter_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WAIT_READY;
                    end
                end else begin
                    state_d = ST_WORKING;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they can be registered alongside it.
    always_comb begin
        req_start_d = MASK_ZERO;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        if (state_d == ST_START) begin
            req_start_d = mask_d;
        end else begin
            req_start_d = MASK_ZERO;
        end
        if (state_d != ST_IDLE) begin
            busy_d = 1'b1;
        end else begin
            busy_d = 1'b0;
        end
        if (state_d == ST_DONE) begin
            done_d = 1'b1;
        end else begin
            done_d = 1'b0;
        end
    end

    // State, configuration and registered outputs; clear acts exactly like reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            nb_iter_q   <= ITER_ZERO;
            mask_q      <= MASK_ZERO;
            iter_q      <= ITER_ZERO;
            done_seen_q <= MASK_ZERO;
            req_start_q <= MASK_ZERO;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else if (clear_i) begin
            state_q     <= ST_IDLE;
            nb_iter_q   <= ITER_ZERO;
            mask_q      <= MASK_ZERO;
            iter_q      <= ITER_ZERO;
            done_seen_q <= MASK_ZERO;
            req_start_q <= MASK_ZERO;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            nb_iter_q   <= nb_iter_d;
            mask_q      <= mask_d;
            iter_q      <= iter_d;
            done_seen_q <= done_seen_d;
            req_start_q <= req_start_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign req_start_o = req_start_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign iter_o      = iter_q;

`ifdef HWPE_STREAM_SEQ_PERF_EN
    logic [31:0] cycles_q, cycles_d;

    // Busy-cycle counter: restarts on an accepted start, saturates instead of wrapping.
    always_comb begin
        cycles_d = cycles_q;
        if ((state_q == ST_IDLE) && start_i) begin
            cycles_d = 32'd0;
        end else if (busy_q && (cycles_q != 32'hFFFF_FFFF)) begin
            cycles_d = cycles_q + 32'd1;
        end else begin
            cycles_d = cycles_q;
        end
    end

    // Busy-cycle counter register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cycles_q <= 32'd0;
        end else if (clear_i) begin
            cycles_q <= 32'd0;
        end else begin
            cycles_q <= cycles_d;
        end
    end

    assign cycles_o = cycles_q;
`endif

endmodule

// File: tb/tb_hwpe_stream_streamer_sequencer.sv
// ---------------------------------------------------------------------------
// Testbench for hwpe_stream_streamer_sequencer (NB_STREAMS=3, CNT_WIDTH=16).
// Jobs are driven transaction by transaction: the bench decides when the
// enabled streamers become ready and in which order their dones arrive (with
// random noise on unmasked/duplicate bits), and derives from those events the
// cycle in which req_start_o, done_o and iter_o must change.
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_hwpe_stream_streamer_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        clear_i;
    logic        start_i;
    logic [15:0] nb_iter_i;
    logic [2:0]  stream_mask_i;
    logic [2:0]  ready_start_i;
    logic [2:0]  done_i;
    logic [2:0]  req_start_o;
    logic        busy_o;
    logic        done_o;
    logic [15:0] iter_o;
`ifdef HWPE_STREAM_SEQ_PERF_EN
    logic [31:0] cycles_o;
`endif

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int job_start_cyc = 0;
    int job_done_cyc = 0;

    always #5 clk_i = ~clk_i;

    hwpe_stream_streamer_sequencer #(
        .NB_STREAMS (3),
        .CNT_WIDTH  (16)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .clear_i       (clear_i),
        .start_i       (start_i),
        .nb_iter_i     (nb_iter_i),
        .stream_mask_i (stream_mask_i),
        .ready_start_i (ready_start_i),
        .done_i        (done_i),
        .req_start_o   (req_start_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .iter_o        (iter_o)
`ifdef HWPE_STREAM_SEQ_PERF_EN
        ,
        .cycles_o      (cycles_o)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    function automatic logic [2:0] rnd3();
        logic [2:0] v;
        v = 3'($urandom_range(0, 7));
        return v;
    endfunction

    function automatic logic rnd1();
        logic v;
        v = 1'($urandom_range(0, 1));
        return v;
    endfunction

    // Called in an IDLE cycle: issues start_i and follows the whole job.
    task automatic run_job(input logic [2:0] mask, input logic [15:0] nb);
        logic [2:0] pending;
        logic [2:0] pick;
        logic [2:0] sub;
        int         gaps;

        start_i       = 1'b1;
        nb_iter_i     = nb;
        stream_mask_i = mask;
        ready_start_i = rnd3() & ~mask;
        done_i        = rnd3();
        job_start_cyc = cyc;
        next_cycle();
        // Config inputs change after the start: the latched copy must be used.
        start_i       = 1'b0;
        nb_iter_i     = 16'($urandom);
        stream_mask_i = rnd3();
        check("busy_after_start", 32'(busy_o), 32'd1);
        check("iter_cleared_at_start", 32'(iter_o), 32'd0);
        check("no_req_first_cycle", 32'(req_start_o), 32'd0);

        if ((nb == 16'd0) || (mask == 3'b000)) begin
            check("done_empty_job", 32'(done_o), 32'd1);
            job_done_cyc  = cyc;
            done_i        = rnd3();
            ready_start_i = rnd3();
            next_cycle();
            check("idle_after_empty_job", 32'(busy_o), 32'd0);
            check("done_single_cycle", 32'(done_o), 32'd0);
            check("no_req_empty_job", 32'(req_start_o), 32'd0);
        end else begin
            check("no_done_first_cycle", 32'(done_o), 32'd0);
            for (int it = 0; it < int'(nb); it++) begin
                // Enabled streamers not all ready yet: nothing may be requested.
                gaps = $urandom_range(0, 3);
                for (int g = 0; g < gaps; g++) begin
                    sub = rnd3() & mask;
                    if (sub == mask) begin
                        sub = 3'b000;
                    end
                    ready_start_i = (rnd3() & ~mask) | sub;
                    done_i        = rnd3();
                    start_i       = rnd1();
                    next_cycle();
                    check("no_req_while_not_ready", 32'(req_start_o), 32'd0);
                    check("busy_waiting", 32'(busy_o), 32'd1);
                    check("no_done_waiting", 32'(done_o), 32'd0);
                end
                ready_start_i = (rnd3() & ~mask) | mask;
                done_i        = rnd3();
                start_i       = rnd1();
                next_cycle();
                check("req_start_mask", 32'(req_start_o), 32'(mask));
                check("iter_at_req", 32'(iter_o), 32'(it));
                // done_i during the request cycle is outside the working phase.
                ready_start_i = rnd3();
                done_i        = rnd3();
                start_i       = rnd1();
                next_cycle();
                check("req_single_cycle", 32'(req_start_o), 32'd0);
                pending = mask;
                gaps    = 0;
                while (pending != 3'b000) begin
                    if ((gaps < 3) && ($urandom_range(0, 2) == 0)) begin
                        done_i = (rnd3() & ~mask) | (rnd3() & mask & ~pending);
                        gaps++;
                    end else begin
                        pick = rnd3() & pending;
                        if (pick == 3'b000) begin
                            pick = pending & (~pending + 3'd1);
                        end
                        done_i  = (rnd3() & ~mask) | (rnd3() & mask & ~pending) | pick;
                        pending = pending & ~pick;
                    end
                    ready_start_i = rnd3();
                    start_i       = rnd1();
                    next_cycle();
                    if (pending != 3'b000) begin
                        check("busy_working", 32'(busy_o), 32'd1);
                        check("no_done_working", 32'(done_o), 32'd0);
                        check("iter_working", 32'(iter_o), 32'(it));
                    end
                end
                // One cycle after the last missing done.
                check("no_req_after_dones", 32'(req_start_o), 32'd0);
                check("iter_after_dones", 32'(iter_o), 32'(it + 1));
                if (it == int'(nb) - 1) begin
                    check("done_pulse", 32'(done_o), 32'd1);
                    job_done_cyc  = cyc;
                    start_i       = 1'b0;
                    done_i        = rnd3();
                    ready_start_i = rnd3();
                    next_cycle();
                    check("done_pulse_ends", 32'(done_o), 32'd0);
                    check("idle_after_job", 32'(busy_o), 32'd0);
                    check("iter_holds", 32'(iter_o), 32'(nb));
                end else begin
                    check("no_done_mid_job", 32'(done_o), 32'd0);
                    check("busy_between_iters", 32'(busy_o), 32'd1);
                end
            end
        end
`ifdef HWPE_STREAM_SEQ_PERF_EN
        check("cycles_count", cycles_o, 32'(job_done_cyc - job_start_cyc));
`endif
        start_i       = 1'b0;
        done_i        = 3'b000;
        ready_start_i = 3'b000;
    endtask

    initial begin
        rst_ni        = 1'b0;
        clear_i       = 1'b0;
        start_i       = 1'b1;
        nb_iter_i     = 16'd1;
        stream_mask_i = 3'b111;
        ready_start_i = 3'b111;
        done_i        = 3'b111;

        // Reset held for two cycles while start_i is high.
        next_cycle();
        next_cycle();
        check("rst_req", 32'(req_start_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_iter", 32'(iter_o), 32'd0);
`ifdef HWPE_STREAM_SEQ_PERF_EN
        check("rst_cycles", cycles_o, 32'd0);
`endif
        rst_ni        = 1'b1;
        start_i       = 1'b0;
        done_i        = 3'b000;
        ready_start_i = 3'b000;
        next_cycle();
        check("idle_after_reset", 32'(busy_o), 32'd0);

        // Directed jobs from the corner cases.
        run_job(3'b111, 16'd2);
        run_job(3'b101, 16'd1);
        run_job(3'b011, 16'd3);
        run_job(3'b111, 16'd0);
        run_job(3'b000, 16'd3);

        // Clear while working: abort without done_o, clear beats a simultaneous start.
        start_i       = 1'b1;
        nb_iter_i     = 16'd3;
        stream_mask_i = 3'b111;
        ready_start_i = 3'b111;
        next_cycle();
        start_i = 1'b0;
        next_cycle();
        check("clr_req_before", 32'(req_start_o), 32'd7);
        ready_start_i = 3'b000;
        next_cycle();
        done_i = 3'b001;
        next_cycle();
        done_i  = 3'b000;
        clear_i = 1'b1;
        start_i = 1'b1;
        next_cycle();
        clear_i = 1'b0;
        start_i = 1'b0;
        check("clr_busy", 32'(busy_o), 32'd0);
        check("clr_done", 32'(done_o), 32'd0);
        check("clr_req", 32'(req_start_o), 32'd0);
        check("clr_iter", 32'(iter_o), 32'd0);
`ifdef HWPE_STREAM_SEQ_PERF_EN
        check("clr_cycles", cycles_o, 32'd0);
`endif
        next_cycle();
        check("clr_start_ignored", 32'(busy_o), 32'd0);
        check("clr_no_done", 32'(done_o), 32'd0);
        run_job(3'b001, 16'd1);

        // Randomized jobs.
        for (int j = 0; j < 24; j++) begin
            run_job(rnd3(), 16'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 1) begin
                next_cycle();
                check("idle_gap", 32'(busy_o), 32'd0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
